// File: rtl/junction_pkg.sv
// Shared encodings for the junction phase scheduler: lamp codes, phases, FSM states.
package junction_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [1:0] {
    MAIN = 2'd0,
    TURN = 2'd1,
    SIDE = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  // Lamps lit in a phase, packed as {M1, M2, MT, S}.
  function automatic logic [3:0] green_mask(input phase_e p);
    logic [3:0] m;
    m = '0;
    case (p)
      MAIN:    m = 4'b1100;
      TURN:    m = 4'b1010;
      SIDE:    m = 4'b0001;
      default: m = '0;
    endcase
    return m;
  endfunction

  // One-hot demand bit belonging to a phase.
  function automatic logic [2:0] phase_bit(input phase_e p);
    logic [2:0] b;
    b = '0;
    case (p)
      MAIN:    b = 3'b001;
      TURN:    b = 3'b010;
      SIDE:    b = 3'b100;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/junction_rr_pick.sv
// Combinational next-phase selector: round-robin scan after the current phase,
// overridden to MAIN by emergency preemption.
module junction_rr_pick
  import junction_pkg::*;
(
  input  logic [2:0] eff,
  input  logic [1:0] phase,
  input  logic       emerg,
  output logic [1:0] next_phase
);

  logic [1:0] cand1;
  logic [1:0] cand2;

  // Scan order phase+1, phase+2 (mod 3); fall back to the current phase.
  always_comb begin
    case (phase)
      MAIN:    begin cand1 = TURN; cand2 = SIDE; end
      TURN:    begin cand1 = SIDE; cand2 = MAIN; end
      default: begin cand1 = MAIN; cand2 = TURN; end
    endcase
    if (emerg)
      next_phase = MAIN;
    else if (eff[cand1])
      next_phase = cand1;
    else if (eff[cand2])
      next_phase = cand2;
    else
      next_phase = phase;
  end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Three-phase junction scheduler: GREEN/YELLOW/ALLRED cycle with min/max green,
// round-robin phase selection and emergency preemption to MAIN.
module junction_phase_scheduler
  import junction_pkg::*;
#(
  parameter int unsigned T_MIN_GREEN = 4,
  parameter int unsigned T_MAX_GREEN = 10,
  parameter int unsigned T_YELLOW    = 2,
  parameter int unsigned T_ALLRED    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       emerg,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [1:0] phase,
  output logic       phase_chg
);

  localparam logic [7:0] MIN_LIM = 8'(T_MIN_GREEN - 1);
  localparam logic [7:0] MAX_LIM = 8'(T_MAX_GREEN - 1);
  localparam logic [7:0] YEL_LIM = 8'(T_YELLOW - 1);
  localparam logic [7:0] AR_LIM  = 8'(T_ALLRED - 1);

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  phase_e     next_phase_q, next_phase_d;
  logic [7:0] timer_q, timer_d;
  logic       phase_chg_q, phase_chg_d;

  logic [2:0] eff;
  logic       other_dem;
  logic       own_dem;
  logic [1:0] pick;

  assign eff       = (req == 3'b000) ? 3'b001 : req;
  assign other_dem = |(eff & ~phase_bit(phase_q));
  assign own_dem   = |(eff & phase_bit(phase_q));

  junction_rr_pick u_pick (
    .eff        (eff),
    .phase      (phase_q),
    .emerg      (emerg),
    .next_phase (pick)
  );

  // State register with asynchronous reset to MAIN GREEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_GREEN;
      phase_q      <= MAIN;
      next_phase_q <= MAIN;
      timer_q      <= '0;
      phase_chg_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      next_phase_q <= next_phase_d;
      timer_q      <= timer_d;
      phase_chg_q  <= phase_chg_d;
    end
  end

  // Next-state, phase latch and cycle timer.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    next_phase_d = next_phase_q;
    phase_chg_d  = 1'b0;
    case (state_q)
      ST_GREEN: begin
        if (emerg) begin
          // MAIN green is held under emergency; any other phase leaves at once.
          if (phase_q != MAIN) begin
            state_d      = ST_YELLOW;
            next_phase_d = MAIN;
          end
        end else if ((timer_q >= MIN_LIM) && other_dem &&
                     (!own_dem || (timer_q >= MAX_LIM))) begin
          state_d      = ST_YELLOW;
          next_phase_d = phase_e'(pick);
        end
      end
      ST_YELLOW: begin
        if (emerg) next_phase_d = MAIN;
        if (timer_q == YEL_LIM) state_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (emerg) next_phase_d = MAIN;
        if (timer_q == AR_LIM) begin
          state_d     = ST_GREEN;
          // Emergency in the last clearance cycle still redirects to MAIN.
          phase_d     = emerg ? MAIN : next_phase_q;
          phase_chg_d = 1'b1;
        end
      end
      default: state_d = ST_GREEN;
    endcase
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q == 8'hFF)
      timer_d = timer_q;
    else
      timer_d = timer_q + 8'd1;
  end

  // Lamp decode from registered state and phase only.
  always_comb begin
    logic [3:0] mask;
    logic [2:0] on_code;
    mask    = green_mask(phase_q);
    on_code = RED;
    case (state_q)
      ST_GREEN:  on_code = GRN;
      ST_YELLOW: on_code = YEL;
      default:   mask    = '0;
    endcase
    light_M1  = mask[3] ? on_code : RED;
    light_M2  = mask[2] ? on_code : RED;
    light_MT  = mask[1] ? on_code : RED;
    light_S   = mask[0] ? on_code : RED;
    phase     = phase_q;
    phase_chg = phase_chg_q;
  end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Scoreboard bench for junction_phase_scheduler: a per-cycle reference model
// built around a queue of planned transition cycles predicts every cycle's outputs.
module tb_junction_phase_scheduler;

  localparam int TMIN = 4;
  localparam int TMAX = 10;
  localparam int TY   = 2;
  localparam int TA   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       emerg;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [1:0] phase;
  logic       phase_chg;

  junction_phase_scheduler #(
    .T_MIN_GREEN (TMIN),
    .T_MAX_GREEN (TMAX),
    .T_YELLOW    (TY),
    .T_ALLRED    (TA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .emerg     (emerg),
    .light_M1  (light_M1),
    .light_M2  (light_M2),
    .light_MT  (light_MT),
    .light_S   (light_S),
    .phase     (phase),
    .phase_chg (phase_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stop_mon = 1'b0;

  // Reference model: phase, age in green, latched next phase, and a queue of
  // upcoming transition cycles (1 = yellow, 2 = all-red). Empty queue = green.
  int m_phase, m_age, m_next;
  bit m_chg;
  int m_plan[$];

  function automatic logic [14:0] ev(input logic [2:0] m1, input logic [2:0] m2,
                                     input logic [2:0] mt, input logic [2:0] s,
                                     input logic [1:0] ph, input logic c);
    return {m1, m2, mt, s, ph, c};
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_age = 0; m_next = 0; m_chg = 1'b0;
    m_plan.delete();
  endfunction

  function automatic logic [14:0] model_out();
    logic [2:0] l[4];
    bit         g[4];
    g[0] = (m_phase != 2);  // M1 in MAIN and TURN
    g[1] = (m_phase == 0);  // M2 in MAIN
    g[2] = (m_phase == 1);  // MT in TURN
    g[3] = (m_phase == 2);  // S in SIDE
    for (int i = 0; i < 4; i++) begin
      if (m_plan.size() == 0)   l[i] = g[i] ? 3'b001 : 3'b100;
      else if (m_plan[0] == 1)  l[i] = g[i] ? 3'b010 : 3'b100;
      else                      l[i] = 3'b100;
    end
    return ev(l[0], l[1], l[2], l[3], 2'(m_phase),
              (m_plan.size() == 0) ? m_chg : 1'b0);
  endfunction

  function automatic void start_transition();
    for (int i = 0; i < TY; i++) m_plan.push_back(1);
    for (int i = 0; i < TA; i++) m_plan.push_back(2);
  endfunction

  function automatic void model_advance(input logic [2:0] r, input logic e);
    logic [2:0] eff;
    bit others;
    int p1, p2;
    eff = (r == 3'b000) ? 3'b001 : r;
    if (m_plan.size() == 0) begin
      m_chg = 1'b0;
      if (e) begin
        if (m_phase != 0) begin m_next = 0; start_transition(); end
        else m_age++;
      end else begin
        others = 1'b0;
        for (int k = 0; k < 3; k++) if (k != m_phase && eff[k]) others = 1'b1;
        if (m_age >= TMIN - 1 && others && (!eff[m_phase] || m_age >= TMAX - 1)) begin
          p1 = (m_phase + 1) % 3;
          p2 = (m_phase + 2) % 3;
          m_next = eff[p1] ? p1 : p2;
          start_transition();
        end else m_age++;
      end
    end else begin
      if (e) m_next = 0;
      void'(m_plan.pop_front());
      if (m_plan.size() == 0) begin
        m_phase = m_next; m_age = 0; m_chg = 1'b1;
      end
    end
  endfunction

  task automatic push_exp(input string name, input logic [14:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs at the falling edge, record what the DUT should show now.
  task automatic step(input logic [2:0] r, input logic e, input logic rv);
    @(negedge clk);
    req = r; emerg = e; rst = rv;
    if (rv) model_reset();
    push_exp("model", model_out());
    if (!rv) model_advance(r, e);
  endtask

  // Assert reset between clock edges; outputs must follow before the next edge.
  task automatic async_reset_mid(input string name);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    push_exp(name, ev(3'b001, 3'b001, 3'b100, 3'b100, 2'd0, 1'b0));
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t        e;
    logic [14:0] act;
    while (!stop_mon) begin
      @(negedge clk or posedge rst);
      #2;
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {light_M1, light_M2, light_MT, light_S, phase, phase_chg};
        n_cmp++;
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s t=%0t: got %b want %b", e.name, $time, act, e.val);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [14:0] s2[8];
    int guard;
    req = 3'b000; emerg = 1'b0; rst = 1'b1;
    model_reset();

    // Idle: no demand keeps MAIN green, no phase change.
    repeat (3) step(3'b000, 1'b0, 1'b1);
    repeat (50) step(3'b000, 1'b0, 1'b0);

    // SIDE demand from reset release, with explicit per-cycle expectations.
    for (int c = 0; c < 4; c++) s2[c] = ev(3'b001, 3'b001, 3'b100, 3'b100, 2'd0, 1'b0);
    s2[4] = ev(3'b010, 3'b010, 3'b100, 3'b100, 2'd0, 1'b0);
    s2[5] = s2[4];
    s2[6] = ev(3'b100, 3'b100, 3'b100, 3'b100, 2'd0, 1'b0);
    s2[7] = ev(3'b100, 3'b100, 3'b100, 3'b001, 2'd2, 1'b1);
    repeat (2) step(3'b000, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step(3'b100, 1'b0, 1'b0);
      push_exp($sformatf("side_from_reset_c%0d", c), s2[c]);
    end

    // SIDE with TURN+SIDE demand held: max green, then TURN.
    repeat (30) step(3'b110, 1'b0, 1'b0);

    // Emergency at SIDE timer 1, then MAIN held under emergency.
    repeat (2) step(3'b000, 1'b0, 1'b1);
    guard = 0;
    while (!(m_phase == 2 && m_chg) && guard < 40) begin
      step(3'b100, 1'b0, 1'b0);
      guard++;
    end
    step(3'b100, 1'b0, 1'b0);
    repeat (25) step(3'b110, 1'b1, 1'b0);

    // From MAIN with TURN+SIDE demand, then back to rest.
    repeat (60) step(3'b110, 1'b0, 1'b0);
    repeat (30) step(3'b000, 1'b0, 1'b0);

    // Asynchronous reset mid-YELLOW.
    guard = 0;
    while (!(m_plan.size() != 0 && m_plan[0] == 1) && guard < 40) begin
      step(3'b100, 1'b0, 1'b0);
      guard++;
    end
    async_reset_mid("async_rst_mid_yellow");
    repeat (2) step(3'b100, 1'b0, 1'b1);
    repeat (20) step(3'b000, 1'b0, 1'b0);

    // Randomized traffic with sparse emergencies and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_mid("async_rst_random");
        step(3'(($urandom_range(0, 7))), 1'b0, 1'b1);
      end else begin
        step(3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0), 1'b0);
      end
    end

    @(negedge clk);
    stop_mon = 1'b1;
  end

endmodule

// File: doc/junction_phase_scheduler.md
JUNCTION_PHASE_SCHEDULER -- requirements
Module: junction_phase_scheduler

Interface
REQ-001 Parameter T_MIN_GREEN, default 4, minimum green time in clk cycles (legal range 1..255).
REQ-002 Parameter T_MAX_GREEN, default 10, maximum green time when competing demand exists (legal range T_MIN_GREEN..255).
REQ-003 Parameter T_YELLOW, default 2, yellow interval in cycles (legal range 1..255).
REQ-004 Parameter T_ALLRED, default 1, all-red clearance in cycles (legal range 1..255).
REQ-005 The port list SHALL be as follows:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  3  phase demand: bit0 MAIN, bit1 TURN, bit2 SIDE; level-sensitive.
- emerg  input  1  emergency preemption to MAIN; level-sensitive.
- light_M1, light_M2, light_MT, light_S  output  3 each  lamp code: 3'b100 red, 3'b010 yellow, 3'b001 green.
- phase  output  2  current phase: 0 MAIN, 1 TURN, 2 SIDE.
- phase_chg  output  1  one-cycle pulse on the first GREEN cycle of a new phase.

Function
REQ-006 The FSM SHALL have three states: GREEN, YELLOW and ALLRED. A cycle timer (8 bits) SHALL clear on every state change and otherwise increment, saturating at 255.
REQ-007 Greens per phase SHALL be:
- MAIN: M1 and M2 green.
- TURN: M1 and MT green.
- SIDE: S green.
- All other lamps: red.
REQ-008 In YELLOW, every lamp that was green in the current phase SHALL show 3'b010 and all others red. In ALLRED, all four lamps SHALL show 3'b100.
REQ-009 Effective demand eff = req, with bit0 forced to 1 when req==3'b000. MAIN is the rest phase.
REQ-010 GREEN SHALL exit to YELLOW after the cycle in which all of the following hold:
- timer >= T_MIN_GREEN-1;
- eff has a bit set other than the current phase;
- eff[phase]==0 or timer >= T_MAX_GREEN-1.
REQ-011 On GREEN exit, the next phase SHALL be latched as the first set bit of eff, scanning phase+1, then phase+2 (mod 3). Within a phase the latch is round-robin.
REQ-012 YELLOW SHALL last exactly T_YELLOW cycles. ALLRED SHALL last exactly T_ALLRED cycles. ALLRED SHALL then enter GREEN of the latched phase with timer=0 and phase_chg=1.
REQ-013 Emergency preemption SHALL work as follows:
- emerg=1 in GREEN with phase!=MAIN: exit to YELLOW on the next edge, ignoring T_MIN_GREEN, with next phase = MAIN.
- emerg=1 in YELLOW or ALLRED: force the latched next phase to MAIN.
- emerg=1 in MAIN GREEN: hold MAIN and suppress any exit.
REQ-014 Changes in req during YELLOW or ALLRED SHALL NOT alter the latched next phase; only emerg may, per REQ-013.
REQ-015 Outputs SHALL be registered or decoded from registered state only, with no combinational path from req or emerg to any output.

Reset
REQ-016 While rst=1, the block SHALL immediately, without waiting for a clock edge, drive:
- state=GREEN, phase=MAIN, timer=0, phase_chg=0;
- light_M1=light_M2=3'b001, light_MT=light_S=3'b100.
REQ-017 The first rising edge after rst falls SHALL be timer cycle 0 of MAIN GREEN. Reset asserted mid-YELLOW or mid-ALLRED SHALL abandon that sequence entirely.

Structure
REQ-018 A shared package junction_pkg SHALL hold:
- lamp code constants (RED, YEL, GRN);
- the phase encoding (MAIN, TURN, SIDE);
- the FSM state encoding.
REQ-019 The next-phase selection SHALL be one sub-module, junction_rr_pick (inputs: eff, phase, emerg; output: next phase). It SHALL be purely combinational.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, all with default parameters:
- Reset release, req=000, 50 cycles -> M1=M2=001 and MT=S=100 throughout; phase_chg never asserted.
- req=100 from reset release -> cycles 0-3 MAIN green; cycles 4-5 M1=M2=010; cycle 6 all 100; cycle 7 S=001, phase=2, phase_chg=1.
- In SIDE with req=110 held -> SIDE green exactly 10 cycles, then 2 yellow, 1 all-red, then TURN (M1=001, MT=001).
- In SIDE at timer=1, emerg=1 -> next cycle S=010 for 2 cycles, 1 all-red, then MAIN; MAIN held while emerg=1 even with req=110.
- In MAIN with req=110 -> TURN is served first, then SIDE, then MAIN once req returns to 000.
- rst asserted asynchronously mid-YELLOW, between clock edges -> outputs take reset values before the next edge.
